tone_rom_sequencer: RTL and testbench
=====================================

TONE_ROM_SEQUENCER -- requirements
Module: tone_rom_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, sample/ROM word width; ADDR_WIDTH, default 7, ROM address width (128 entries); LOOP_WIDTH, default 16, loop counter width.
REQ-002 Port wb_clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-003 Port wb_rst_i, input, 1: reset, synchronous, active-high.
REQ-004 Port start_i, input, 1: one-cycle request to begin playback.
REQ-005 Port stop_i, input, 1: abort playback.
REQ-006 Port period_len_i, input, ADDR_WIDTH: ROM entries per tone period; 0 means 2**ADDR_WIDTH.
REQ-007 Port loop_cnt_i, input, LOOP_WIDTH: periods to play; 0 means play until stop_i.
REQ-008 Port rom_addr_o, output, ADDR_WIDTH: address to the asynchronous-read tone ROM.
REQ-009 Port rom_q_i, input, DATA_WIDTH: ROM data, valid in the same cycle as rom_addr_o.
REQ-010 Port sample_o, output, DATA_WIDTH: registered sample toward the I2S transmit path.
REQ-011 Port sample_valid_o, output, 1: sample_o holds a sample.
REQ-012 Port sample_ready_i, input, 1: consumer accepts sample_o this cycle.
REQ-013 Port busy_o, output, 1: high in every state except IDLE.
REQ-014 Port done_o, output, 1: one-cycle pulse on normal completion.

Function
REQ-015 FSM states SHALL be IDLE, FETCH and HOLD.
REQ-016 IDLE: on start_i=1 and stop_i=0, latch period_len_i and loop_cnt_i, set rom_addr_o=0, go to FETCH; start_i in any other state SHALL be ignored.
REQ-017 FETCH: register rom_q_i into sample_o, set sample_valid_o=1, go to HOLD; this state lasts exactly one cycle.
REQ-018 HOLD: sample_o and sample_valid_o SHALL stay stable until sample_valid_o & sample_ready_i (the transfer).
REQ-019 On transfer with rom_addr_o != latched period length - 1: increment rom_addr_o, clear sample_valid_o, go to FETCH.
REQ-020 On transfer at the last address: rom_addr_o wraps to 0; the remaining-loop counter decrements unless the latched loop count is 0.
REQ-021 When the transfer completes the final period, done_o SHALL pulse for the following cycle, sample_valid_o SHALL clear, and the FSM SHALL go to IDLE.
REQ-022 Otherwise, after the wrap the FSM SHALL go to FETCH.
REQ-023 Peak throughput SHALL be one sample per 2 cycles, and the latency from start_i to the first sample_valid_o SHALL be 2 cycles.
REQ-024 stop_i in FETCH or HOLD SHALL take priority over a transfer in the same cycle.
REQ-025 On such a stop, the next cycle SHALL have sample_valid_o=0, rom_addr_o=0 and state IDLE, with no done_o.
REQ-026 Simultaneous start_i and stop_i in IDLE SHALL leave the block in IDLE.
REQ-027 Address arithmetic SHALL be modulo 2**ADDR_WIDTH.
REQ-028 A period length of 0 SHALL wrap after address 2**ADDR_WIDTH-1.
REQ-029 Changes on period_len_i and loop_cnt_i while busy_o=1 SHALL have no effect until the next start.

Reset
REQ-030 With wb_rst_i=1 at a clock edge: state IDLE; rom_addr_o, sample_o, sample_valid_o, busy_o, done_o and internal counters all 0.
REQ-031 Reset asserted mid-playback SHALL override every other input in that cycle, including a pending transfer; no done_o pulse.

Configuration
REQ-032 Macro TONE_SEQ_MUTE_EN: when defined, the block SHALL add input port mute_i (1 bit).
REQ-033 With TONE_SEQ_MUTE_EN defined, FETCH SHALL register zero into sample_o while mute_i=1; sequencing, addressing, handshakes and loop counting SHALL be unchanged.
REQ-034 With TONE_SEQ_MUTE_EN undefined, mute_i SHALL not exist, and sample_o SHALL always equal the registered rom_q_i.

Verification
REQ-035 Reset: pulse wb_rst_i during HOLD at address 5 -> next cycle rom_addr_o=0, sample_valid_o=0, busy_o=0, done_o never asserted.
REQ-036 Single period: period_len_i=4, loop_cnt_i=1, ROM[n]=n+0x100, ready tied high -> samples 0x100..0x103 on cycles 2,4,6,8 after start, then done_o pulses once, busy_o falls.
REQ-037 Backpressure: sample_ready_i low for 10 cycles in HOLD -> sample_o and sample_valid_o constant for 10 cycles; next transfer advances the address by exactly 1.
REQ-038 Wrap and loops: period_len_i=0, loop_cnt_i=2 -> 256 samples, address sequence 0..127,0..127, single done_o pulse.
REQ-039 Stop: loop_cnt_i=0; stop_i coincident with a transfer at address 3 -> no further sample, IDLE next cycle, no done_o; start_i with stop_i in IDLE -> remains IDLE.
REQ-040 Mute (TONE_SEQ_MUTE_EN defined): mute_i=1 across samples 2..3 of a 4-sample period -> sample_o 0 for exactly those two transfers, same done_o timing as the unmuted run.

Source files
------------

// File: rtl/tone_rom_sequencer.sv
// Tone ROM sequencer: walks a tone ROM one period at a time for a set number of loops.
// Optional TONE_SEQ_MUTE_EN macro adds mute_i, which zeroes fetched samples.
module tone_rom_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [ADDR_WIDTH-1:0] period_len_i,
  input  logic [LOOP_WIDTH-1:0] loop_cnt_i,
`ifdef TONE_SEQ_MUTE_EN
  input  logic                  mute_i,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LOOP_WIDTH-1:0] LOOP_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] period_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [LOOP_WIDTH-1:0] loops_q;
  logic [LOOP_WIDTH-1:0] loops_left;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  xfer;
  logic                  at_last;
  logic                  final_period;

  // A latched period of 0 makes last_addr all ones, i.e. a full ROM sweep.
  assign last_addr    = period_q - ADDR_ONE;
  assign xfer         = sample_valid_o & sample_ready_i;
  assign at_last      = (rom_addr_o == last_addr);
  assign final_period = (loops_q != '0) && (loops_left == LOOP_ONE);

`ifdef TONE_SEQ_MUTE_EN
  assign fetch_data = mute_i ? '0 : rom_q_i;
`else
  assign fetch_data = rom_q_i;
`endif

  // Playback FSM: fetch a ROM word, hold it until accepted, advance or finish.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      period_q       <= '0;
      loops_q        <= '0;
      loops_left     <= '0;
      rom_addr_o     <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i && !stop_i) begin
            period_q   <= period_len_i;
            loops_q    <= loop_cnt_i;
            loops_left <= loop_cnt_i;
            rom_addr_o <= '0;
            busy_o     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (stop_i) begin
            rom_addr_o     <= '0;
            sample_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            state          <= IDLE;
          end else begin
            sample_o       <= fetch_data;
            sample_valid_o <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (stop_i) begin
            rom_addr_o     <= '0;
            sample_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            state          <= IDLE;
          end else if (xfer) begin
            sample_valid_o <= 1'b0;
            if (!at_last) begin
              rom_addr_o <= rom_addr_o + ADDR_ONE;
              state      <= FETCH;
            end else begin
              rom_addr_o <= '0;
              if (final_period) begin
                loops_left <= '0;
                busy_o     <= 1'b0;
                done_o     <= 1'b1;
                state      <= IDLE;
              end else begin
                if (loops_q != '0)
                  loops_left <= loops_left - LOOP_ONE;
                state <= FETCH;
              end
            end
          end
        end
        default: begin
          rom_addr_o     <= '0;
          sample_valid_o <= 1'b0;
          busy_o         <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_rom_sequencer.sv
// Bench for tone_rom_sequencer: random runs checked against a
// transfer-level model of the expected sample stream.
module tb_tone_rom_sequencer;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int LW = 16;
  localparam int DEPTH = 1 << AW;

`ifdef TONE_SEQ_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] period_len = '0;
  logic [LW-1:0] loop_cnt = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] sample;
  logic          valid;
  logic          ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef TONE_SEQ_MUTE_EN
  logic          mute = 1'b0;
`endif

  logic [DW-1:0] rom [DEPTH];

  int n_chk = 0;
  int n_fail = 0;

  assign rom_q = rom[addr];

  always #5 clk = ~clk;

  tone_rom_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LOOP_WIDTH(LW)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .start_i       (start),
    .stop_i        (stop),
    .period_len_i  (period_len),
    .loop_cnt_i    (loop_cnt),
`ifdef TONE_SEQ_MUTE_EN
    .mute_i        (mute),
`endif
    .rom_addr_o    (addr),
    .rom_q_i       (rom_q),
    .sample_o      (sample),
    .sample_valid_o(valid),
    .sample_ready_i(ready),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_sample(input int a, input int i,
                                               input int lo, input int hi);
    if (MUTE_EN && i >= lo && i <= hi)
      return '0;
    return rom[a];
  endfunction

  task automatic set_mute(input int i, input int lo, input int hi);
`ifdef TONE_SEQ_MUTE_EN
    mute = (i >= lo && i <= hi);
`else
    if (i < lo && i > hi) $display("unreachable");
`endif
  endtask

  // abort_kind: 0 none, 1 stop_i, 2 wb_rst_i, applied on the
  // transfer cycle of sample index abort_at.
  task automatic play(input int p, input int l, input int rdy_pct,
                      input int abort_at, input int abort_kind,
                      input int mute_lo, input int mute_hi);
    int  plen, total, idx, cyc;
    bit  running, fetch, fin, aborted, v, r;
    plen  = (p == 0) ? DEPTH : p;
    total = (l == 0) ? (1 << 30) : plen * l;
    idx = 0;
    start = 1'b1;
    stop = 1'b0;
    period_len = p[AW-1:0];
    loop_cnt = l[LW-1:0];
    ready = 1'b0;
    set_mute(0, mute_lo, mute_hi);
    @(negedge clk);
    start = 1'b0;
    running = 1'b1;
    fetch = 1'b1;
    fin = 1'b0;
    aborted = 1'b0;
    cyc = 1;
    while (running && cyc < 5000) begin
      period_len = AW'($urandom);
      loop_cnt = LW'($urandom);
      start = $urandom_range(1);
      v = !fetch;
      chk("busy", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      chk("valid", 64'(valid), 64'(v));
      chk("addr", 64'(addr), 64'(idx % plen));
      if (v)
        chk("sample", 64'(sample),
            64'(exp_sample(idx % plen, idx, mute_lo, mute_hi)));
      r = ($urandom_range(99) < rdy_pct);
      if (v && abort_kind != 0 && idx == abort_at) begin
        r = 1'b1;
        if (abort_kind == 1) stop = 1'b1;
        else rst = 1'b1;
        aborted = 1'b1;
        running = 1'b0;
      end else if (v && r) begin
        idx++;
        fetch = 1'b1;
        if (idx == total) begin
          fin = 1'b1;
          running = 1'b0;
        end
      end else begin
        fetch = 1'b0;
      end
      ready = r;
      set_mute(idx, mute_lo, mute_hi);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    stop = 1'b0;
    rst = 1'b0;
    ready = 1'b0;
    set_mute(-1, mute_lo, mute_hi);
    chk("timeout", 64'(running), 64'd0);
    chk("done_end", 64'(done), 64'(fin));
    chk("busy_end", 64'(busy), 64'd0);
    chk("valid_end", 64'(valid), 64'd0);
    chk("addr_end", 64'(addr), 64'd0);
    if (aborted && abort_kind == 2)
      chk("sample_rst", 64'(sample), 64'd0);
    @(negedge clk);
    chk("done_once", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      rom[i] = DW'(i + 32'h100);
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    play(4, 1, 100, -1, 0, -1, -1);
    play(4, 1, 100, -1, 0, 1, 2);

    for (int i = 0; i < DEPTH; i++)
      rom[i] = $urandom;
    play(6, 2, 30, -1, 0, -1, -1);
    play(0, 2, 100, -1, 0, -1, -1);
    play(0, 0, 100, 3, 1, -1, -1);
    play(8, 0, 50, 5, 2, -1, -1);

    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", 64'(busy), 64'd0);
    chk("ss_valid", 64'(valid), 64'd0);
    @(negedge clk);
    chk("ss_busy2", 64'(busy), 64'd0);

    for (int k = 0; k < 6; k++)
      play($urandom_range(20, 1), $urandom_range(3, 1),
           $urandom_range(100, 20), -1, 0,
           $urandom_range(5), $urandom_range(10, 5));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
